// File: rtl/instmem_pkg.sv
// instmem_pkg: shared constants, FSM state type and address helpers for instr_mem_bank.
package instmem_pkg;
  localparam logic [63:0] INSTMEM_NOP = '0;
  typedef enum logic {INIT, RUN} state_t;
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned sh);
    return addr >> sh;
  endfunction
  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth, input int unsigned sh);
    return ((addr & ((64'd1 << sh) - 64'd1)) == 64'd0) && ((addr >> sh) < 64'(depth));
  endfunction
endpackage

// File: rtl/instr_mem_bank_if.sv
// instr_mem_bank_if: fetch port, load port and status flags of the instruction memory.
interface instr_mem_bank_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic              fetch_req, fetch_ready, instr_valid, instr_fault;
  logic              load_we, load_fault, init_done, instr_par_err;
  logic [ADDR_W-1:0] fetch_addr, load_addr;
  logic [DATA_W-1:0] instr, load_data;
  modport master(output fetch_req, fetch_addr, load_we, load_addr, load_data,
                 input fetch_ready, instr_valid, instr, instr_fault, load_fault, init_done, instr_par_err);
  modport slave(input fetch_req, fetch_addr, load_we, load_addr, load_data,
                output fetch_ready, instr_valid, instr, instr_fault, load_fault, init_done, instr_par_err);
endinterface

// File: rtl/instmem_init_ctrl.sv
// instmem_init_ctrl: INIT/RUN FSM that walks every word once after reset to clear memory.
module instmem_init_ctrl import instmem_pkg::*; #(
  parameter int DEPTH_WORDS = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_we,
  output logic [IDX_W-1:0] init_idx,
  output logic             init_done
);
  state_t state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == IDX_W'(DEPTH_WORDS - 1)) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end
  assign init_we = (state == INIT);
endmodule

// File: rtl/instr_mem_bank.sv
// instr_mem_bank: word-organised instruction memory with fetch/load ports and post-reset clear.
// Optional stored even parity per word when INSTMEM_PARITY_EN is defined.
module instr_mem_bank import instmem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 32
) (
  input logic             clk,
  input logic             rst,
  instr_mem_bank_if.slave bus
);
  localparam int SH    = $clog2(DATA_W / 8);
  localparam int IDX_W = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic             init_we, init_done, accept, fetch_ok, load_ok, load_en, par_chk;
  logic [IDX_W-1:0] init_idx, fetch_idx, load_idx;
  instmem_init_ctrl #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_init (
    .clk(clk), .rst(rst), .init_we(init_we), .init_idx(init_idx), .init_done(init_done)
  );
  assign fetch_ok  = addr_ok(64'(bus.fetch_addr), DEPTH_WORDS, SH);
  assign load_ok   = addr_ok(64'(bus.load_addr), DEPTH_WORDS, SH);
  assign fetch_idx = IDX_W'(word_idx(64'(bus.fetch_addr), SH));
  assign load_idx  = IDX_W'(word_idx(64'(bus.load_addr), SH));
  assign accept    = init_done & bus.fetch_req;
  assign load_en   = init_done & bus.load_we & load_ok;
  assign bus.fetch_ready = init_done;
  assign bus.init_done   = init_done;
  always_ff @(posedge clk) begin
    if (init_we) mem[init_idx] <= DATA_W'(INSTMEM_NOP);
    else if (load_en) mem[load_idx] <= bus.load_data;
  end
`ifdef INSTMEM_PARITY_EN
  logic par [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (init_we) par[init_idx] <= ^DATA_W'(INSTMEM_NOP);
    else if (load_en) par[load_idx] <= ^bus.load_data;
  end
  assign par_chk = accept & fetch_ok & (par[fetch_idx] != ^mem[fetch_idx]);
`else
  assign par_chk = 1'b0;
`endif
  // Read-first: the array read here sees the word before any same-edge load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr_valid   <= 1'b0;
      bus.instr_fault   <= 1'b0;
      bus.instr         <= '0;
      bus.load_fault    <= 1'b0;
      bus.instr_par_err <= 1'b0;
    end else begin
      bus.instr_valid   <= accept;
      bus.instr_fault   <= accept & ~fetch_ok;
      bus.load_fault    <= init_done & bus.load_we & ~load_ok;
      bus.instr_par_err <= par_chk;
      if (accept) bus.instr <= fetch_ok ? mem[fetch_idx] : DATA_W'(INSTMEM_NOP);
    end
  end
endmodule
